// File: rtl/ram_arbiter_2p.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Read data is returned to the issuing port through a READ_LATENCY-deep tag pipe.
module ram_arbiter_2p #(
   parameter int W_ADDR       = 13,
   parameter int W_DATA       = 16,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        Req,
   input  logic [1:0]        Wr,
   input  logic [W_ADDR-1:0] Addr0,
   input  logic [W_ADDR-1:0] Addr1,
   input  logic [W_DATA-1:0] WData0,
   input  logic [W_DATA-1:0] WData1,
   output logic [1:0]        Grant,
   output logic [1:0]        RValid,
   output logic [W_DATA-1:0] RData,
   output logic [W_ADDR-1:0] RamAddress,
   output logic [W_DATA-1:0] RamDataIn,
   output logic              RamWrEn,
   input  logic [W_DATA-1:0] RamDataOut,
   output logic              DbgPrio
);

   // Handshake: Req[p] is valid, Grant[p] is ready; the access transfers at the
   // rising edge where both are high. While Req[p]=1 and Grant[p]=0 the
   // requester holds Wr[p], Addr/WData of port p stable.

   if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
      $error("ram_arbiter_2p: READ_LATENCY must be 1 or 2");
   end

   logic       prio;
   logic [1:0] grant;
   logic       gidx;
   logic       rd_push;
   logic       tag_v [READ_LATENCY];
   logic       tag_p [READ_LATENCY];

   // Reset forces no grant so the RAM sees only idle cycles.
   always_comb begin
      grant = 2'b00;
      if (rst) begin
         case (Req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

   assign gidx    = grant[1];
   assign Grant   = grant;
   assign rd_push = (|grant) & ~Wr[gidx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prio <= 1'b0;
      end else if (|grant) begin
         prio <= ~gidx;
      end
   end

   // Tag stage i holds the read issued i+1 edges ago; the last stage lines up
   // with the RAM output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            tag_v[i] <= 1'b0;
            tag_p[i] <= 1'b0;
         end
      end else begin
         tag_v[0] <= rd_push;
         tag_p[0] <= gidx;
         for (int i = 1; i < READ_LATENCY; i++) begin
            tag_v[i] <= tag_v[i-1];
            tag_p[i] <= tag_p[i-1];
         end
      end
   end

   assign RValid  = {tag_v[READ_LATENCY-1] &  tag_p[READ_LATENCY-1],
                     tag_v[READ_LATENCY-1] & ~tag_p[READ_LATENCY-1]};
   assign RData   = RamDataOut;
   assign DbgPrio = prio;

   always_comb begin
      RamAddress = '0;
      RamDataIn  = '0;
      RamWrEn    = 1'b0;
      if (grant[0]) begin
         RamAddress = Addr0;
         RamDataIn  = WData0;
         RamWrEn    = Wr[0];
      end else if (grant[1]) begin
         RamAddress = Addr1;
         RamDataIn  = WData1;
         RamWrEn    = Wr[1];
      end
   end

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Bench for ram_arbiter_2p: directed scenarios then random traffic, checked
// against a request-level model with a reference memory and expected-read queue.
module tb_ram_arbiter_2p;

   localparam int W_ADDR = 13;
   localparam int W_DATA = 16;
   localparam int LAT    = 1;
   localparam int QW     = 33;   // {due cycle[15:0], port, data[15:0]}

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]        Req, Wr, Grant, RValid;
   logic [W_ADDR-1:0] Addr0, Addr1, RamAddress;
   logic [W_DATA-1:0] WData0, WData1, RData, RamDataIn, RamDataOut;
   logic              RamWrEn, DbgPrio;

   ram_arbiter_2p #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .READ_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .Req(Req), .Wr(Wr),
      .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
      .Grant(Grant), .RValid(RValid), .RData(RData),
      .RamAddress(RamAddress), .RamDataIn(RamDataIn), .RamWrEn(RamWrEn),
      .RamDataOut(RamDataOut), .DbgPrio(DbgPrio)
   );

   // Synchronous single-port RAM the arbiter drives.
   logic [W_DATA-1:0] ram [8192];
   logic [W_DATA-1:0] rd_p1, rd_p2;
   always @(posedge clk) begin
      if (RamWrEn) ram[RamAddress] <= RamDataIn;
      rd_p1 <= ram[RamAddress];
      rd_p2 <= rd_p1;
   end
   assign RamDataOut = (LAT == 1) ? rd_p1 : rd_p2;

   // ---------------- reference model / scoreboard ----------------
   logic [W_DATA-1:0] ref_mem [8192];
   logic [QW-1:0]     exp_q[$];
   int                favoured;
   int                wait_cnt [2];
   int                cyc;
   logic [1:0]        last_grant;
   int                n_checks;
   int                n_fail;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: check outputs mid-cycle, then apply the access to the model.
   task automatic step();
      logic [1:0]        g;
      int                w;
      logic [W_ADDR-1:0] a;
      logic [W_DATA-1:0] d;
      logic              we;
      logic [QW-1:0]     e;
      logic [1:0]        rv_exp;
      logic [W_DATA-1:0] rd_exp;
      @(negedge clk);
      g = 2'b00;
      if (rst) begin
         if (Req == 2'b11) g = (favoured == 0) ? 2'b01 : 2'b10;
         else              g = Req;
      end
      w  = g[1] ? 1 : 0;
      a  = (g == 2'b00) ? '0 : ((w == 1) ? Addr1 : Addr0);
      d  = (g == 2'b00) ? '0 : ((w == 1) ? WData1 : WData0);
      we = (g == 2'b00) ? 1'b0 : Wr[w];
      check("grant", 32'(Grant), 32'(g));
      check("ram_addr", 32'(RamAddress), 32'(a));
      check("ram_din", 32'(RamDataIn), 32'(d));
      check("ram_we", 32'(RamWrEn), 32'(we));
      check("prio", 32'(DbgPrio), 32'(favoured));
      rv_exp = 2'b00;
      rd_exp = '0;
      if (exp_q.size() > 0 && exp_q[0][32:17] == cyc[15:0]) begin
         e      = exp_q.pop_front();
         rv_exp = e[16] ? 2'b10 : 2'b01;
         rd_exp = e[15:0];
      end
      check("rvalid", 32'(RValid), 32'(rv_exp));
      if (rv_exp != 2'b00) check("rdata", 32'(RData), 32'(rd_exp));
      for (int p = 0; p < 2; p++) begin
         if (rst && Req[p]) begin
            if (g[p]) begin
               check("starve", 32'(wait_cnt[p] <= 1), 32'd1);
               wait_cnt[p] = 0;
            end else begin
               wait_cnt[p]++;
            end
         end
      end
      last_grant = g;
      @(posedge clk);
      if (g != 2'b00) begin
         if (we) ref_mem[a] = d;
         else    exp_q.push_back({16'(cyc + LAT), w[0], ref_mem[a]});
         favoured = 1 - w;
      end
      cyc++;
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [1:0] req, input logic [1:0] wr,
                        input logic [W_ADDR-1:0] a0, input logic [W_DATA-1:0] d0,
                        input logic [W_ADDR-1:0] a1, input logic [W_DATA-1:0] d1);
      Req = req; Wr = wr; Addr0 = a0; WData0 = d0; Addr1 = a1; WData1 = d1;
   endtask

   task automatic enter_reset();
      rst = 1'b0;
      exp_q.delete();
      favoured    = 0;
      wait_cnt[0] = 0;
      wait_cnt[1] = 0;
   endtask

   task automatic idle(input int n);
      drive(2'b00, 2'b00, '0, '0, '0, '0);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic new_port_req(input int p);
      logic r, w;
      logic [W_ADDR-1:0] a;
      logic [W_DATA-1:0] d;
      r = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1) == 1;
      a = W_ADDR'($urandom_range(0, 15));
      d = W_DATA'($urandom);
      Req[p] = r;
      Wr[p]  = w;
      if (p == 0) begin Addr0 = a; WData0 = d; end
      else        begin Addr1 = a; WData1 = d; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [W_DATA-1:0] v;
      n_checks = 0; n_fail = 0; cyc = 0; last_grant = 2'b00;
      for (int i = 0; i < 8192; i++) begin
         v = W_DATA'($urandom);
         ram[i] = v;
         ref_mem[i] = v;
      end
      enter_reset();
      drive(2'b11, 2'b11, 13'd5, 16'h1234, 13'd6, 16'h5678);
      step();
      step();
      idle(1);
      rst = 1'b1;

      // Single read by port 0
      drive(2'b01, 2'b00, 13'd10, '0, '0, '0);
      step();
      idle(LAT + 1);

      // Two writes, one per port
      drive(2'b01, 2'b01, 13'd11, 16'h8114, '0, '0);
      step();
      drive(2'b10, 2'b10, '0, '0, 13'd12, 16'h2677);
      step();
      idle(LAT + 1);

      // Both ports reading continuously: alternation
      drive(2'b11, 2'b00, 13'd12, '0, 13'd11, '0);
      for (int i = 0; i < 4; i++) step();
      idle(LAT + 1);

      // Write immediately followed by read of the same address
      drive(2'b10, 2'b10, '0, '0, 13'd10, 16'hBEEF);
      step();
      drive(2'b01, 2'b00, 13'd10, '0, '0, '0);
      step();
      idle(LAT + 1);

      // Reset lands on an in-flight read
      drive(2'b10, 2'b00, '0, '0, 13'd3, '0);
      step();
      enter_reset();
      drive(2'b11, 2'b00, 13'd1, '0, 13'd2, '0);
      step();
      step();
      drive(2'b00, 2'b00, '0, '0, '0, '0);
      step();
      rst = 1'b1;
      idle(5);

      // Random traffic with level-held requests
      for (int i = 0; i < 400; i++) begin
         if (last_grant[0] || !Req[0]) new_port_req(0);
         if (last_grant[1] || !Req[1]) new_port_req(1);
         step();
      end
      idle(LAT + 2);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
